// File: rtl/giraffe_pkg.sv
// Shared types and constants for the Giraffe ADC capture-and-stream path:
// FSM state encoding (doubles as the LED code), byte layout and counter width.
package giraffe_pkg;

   // One-hot values so the state register can drive the LEDs unchanged
   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_CAPTURE = 4'b0010,
      ST_DRAIN   = 4'b0100,
      ST_DONE    = 4'b1000
   } state_t;

   localparam int BYTE_CODE_W   = 6;
   localparam int BYTE_SUB_BIT  = 6;
   localparam int DEFAULT_CNT_W = 18;

   function automatic logic [7:0] pack_byte(input logic sub, input logic [BYTE_CODE_W-1:0] code);
      logic [7:0] b;
      b = '0;
      b[BYTE_CODE_W-1:0] = code;
      b[BYTE_SUB_BIT]    = sub;
      return b;
   endfunction

endpackage

// File: rtl/adc_capture_stream_if.sv
// Byte stream towards the UART transmitter: valid/ready handshake.
interface adc_capture_stream_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/adc_byte_fifo.sv
// First-word-fall-through byte FIFO on an inferred RAM with a registered read
// port; pointers carry one extra wrap bit to separate full from empty.
module adc_byte_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    wr_data,
   input  logic          pop,
   output logic [7:0]    rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic [AW:0] rd_ptr_next;
   logic [7:0]  rd_data_reg;
   logic        wr_en;
   logic        rd_en;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign level   = wr_ptr_reg - rd_ptr_reg;
   assign wr_en   = push && (!full || pop);
   assign rd_en   = pop && !empty;
   assign rd_data = rd_data_reg;

   assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, rd_en};

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (wr_en)
            wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Read one slot ahead; a write landing on the next head bypasses the RAM
   always_ff @(posedge clk) begin
      if (rst)
         rd_data_reg <= '0;
      else if (wr_en && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
         rd_data_reg <= wr_data;
      else
         rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
   end

endmodule

// File: rtl/adc_capture_stream.sv
// Synchronises the sub-ADC strobe, packs each code into a byte, buffers it and
// streams it to the UART; stops after NUM_Sampled captures.
module adc_capture_stream
   import giraffe_pkg::*;
#(
   parameter int N_bit       = 6,
   parameter int NUM_Sampled = 102400,
   parameter int FIFO_DEPTH  = 16,
   parameter int CNT_W       = DEFAULT_CNT_W
) (
   input  logic                 clk_50M,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 adc_ack,
   input  logic                 adc_ack_sub,
   input  logic [N_bit-1:0]     dout_adc,
   adc_capture_stream_if.master tx,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow,
   output logic [CNT_W-1:0]     cnt_send,
   output logic [3:0]           state_code
);

   localparam int FIFO_AW = $clog2(FIFO_DEPTH);

   state_t             state_reg;
   state_t             state_next;
   logic [1:0]         ack_sync_reg;
   logic [1:0]         sub_sync_reg;
   logic               ack_prev_reg;
   logic               cap;
   logic [CNT_W-1:0]   cnt_cap_reg;
   logic [CNT_W-1:0]   cnt_send_reg;
   logic               overflow_reg;
   logic               push;
   logic               pop;
   logic               arm;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FIFO_AW:0]   fifo_level;
   logic [7:0]         fifo_data;

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         ack_sync_reg <= '0;
         sub_sync_reg <= '0;
         ack_prev_reg <= 1'b0;
      end else begin
         ack_sync_reg <= {ack_sync_reg[0], adc_ack};
         sub_sync_reg <= {sub_sync_reg[0], adc_ack_sub};
         ack_prev_reg <= ack_sync_reg[1];
      end
   end

   assign cap  = ack_sync_reg[1] && !ack_prev_reg;
   assign push = cap && (state_reg == ST_CAPTURE);
   assign pop  = tx.tx_valid && tx.tx_ready;
   assign arm  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

   adc_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk_50M),
      .rst     (rst),
      .push    (push),
      .wr_data (pack_byte(sub_sync_reg[1], BYTE_CODE_W'(dout_adc))),
      .pop     (pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clk_50M) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE:
            if (start)
               state_next = ST_CAPTURE;
         ST_CAPTURE:
            if (cap && (cnt_cap_reg == CNT_W'(NUM_Sampled - 1)))
               state_next = ST_DRAIN;
         ST_DRAIN:
            if (fifo_empty || (pop && (fifo_level == (FIFO_AW + 1)'(1))))
               state_next = ST_DONE;
         default:
            state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      state_code = state_reg;
      busy       = (state_reg == ST_CAPTURE) || (state_reg == ST_DRAIN);
      done       = (state_reg == ST_DONE);
   end

   // A pop in the same cycle frees the slot, so a full FIFO only drops without one
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         cnt_cap_reg  <= '0;
         cnt_send_reg <= '0;
         overflow_reg <= 1'b0;
      end else if (arm) begin
         cnt_cap_reg  <= '0;
         cnt_send_reg <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (pop)
            cnt_send_reg <= cnt_send_reg + CNT_W'(1);
         if (push) begin
            cnt_cap_reg <= cnt_cap_reg + CNT_W'(1);
            if (fifo_full && !pop)
               overflow_reg <= 1'b1;
         end
      end
   end

   assign tx.tx_valid = busy && !fifo_empty;
   assign tx.tx_data  = tx.tx_valid ? fifo_data : 8'h00;
   assign cnt_send    = cnt_send_reg;
   assign overflow    = overflow_reg;

endmodule

// File: tb/tb_adc_capture_stream.sv
// Directed bench for adc_capture_stream: a queue-based model of the acquisition
// is compared against the outputs every cycle, plus literal end-of-test checks.
module tb_adc_capture_stream;

   localparam int NUM   = 20;
   localparam int DEPTH = 16;
   localparam int CW    = 18;

   logic          clk_50M     = 1'b0;
   logic          rst         = 1'b1;
   logic          start       = 1'b0;
   logic          adc_ack     = 1'b0;
   logic          adc_ack_sub = 1'b0;
   logic [5:0]    dout_adc    = '0;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [CW-1:0] cnt_send;
   logic [3:0]    state_code;

   adc_capture_stream_if tx_if ();

   adc_capture_stream #(
      .N_bit(6), .NUM_Sampled(NUM), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
   ) dut (
      .clk_50M     (clk_50M),
      .rst         (rst),
      .start       (start),
      .adc_ack     (adc_ack),
      .adc_ack_sub (adc_ack_sub),
      .dout_adc    (dout_adc),
      .tx          (tx_if),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .cnt_send    (cnt_send),
      .state_code  (state_code)
   );

   always #10 clk_50M = ~clk_50M;

   int n_vec = 0;
   int n_mis = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Acquisition model: states as LED codes, FIFO as a queue of bytes
   logic [3:0] m_code = 4'b0001;
   logic [7:0] m_q[$];
   int         m_cap = 0;
   int         m_send = 0;
   bit         m_ovf = 1'b0;
   int         hi_cnt = 0;
   bit         m_rst_last = 1'b1;

   always @(posedge clk_50M) begin
      int occ;
      bit valid;
      bit xfer;
      bit capev;
      m_rst_last = rst;
      if (rst) begin
         m_code = 4'b0001;
         m_q.delete();
         m_cap = 0;
         m_send = 0;
         m_ovf = 1'b0;
         hi_cnt = 0;
      end else begin
         occ   = m_q.size();
         valid = ((m_code == 4'b0010) || (m_code == 4'b0100)) && (occ > 0);
         xfer  = valid && tx_if.tx_ready;
         // strobe is seen on the third edge after it rises (2-FF sync + edge detect)
         capev  = (hi_cnt == 2);
         hi_cnt = adc_ack ? hi_cnt + 1 : 0;
         if (xfer) begin
            void'(m_q.pop_front());
            m_send++;
         end
         case (m_code)
            4'b0001, 4'b1000:
               if (start) begin
                  m_code = 4'b0010;
                  m_cap  = 0;
                  m_send = 0;
                  m_ovf  = 1'b0;
               end
            4'b0010:
               if (capev) begin
                  m_cap++;
                  if (occ < DEPTH || xfer)
                     m_q.push_back({1'b0, adc_ack_sub, dout_adc});
                  else
                     m_ovf = 1'b1;
                  if (m_cap == NUM)
                     m_code = 4'b0100;
               end
            4'b0100:
               if (m_q.size() == 0)
                  m_code = 4'b1000;
            default: ;
         endcase
      end
   end

   logic [7:0] rx_q[$];
   bit         stall_prev = 1'b0;
   logic [7:0] data_prev  = '0;

   always @(negedge clk_50M) begin
      bit         exp_busy;
      bit         exp_valid;
      logic [7:0] exp_data;
      exp_busy  = (m_code == 4'b0010) || (m_code == 4'b0100);
      exp_valid = exp_busy && (m_q.size() > 0);
      exp_data  = exp_valid ? m_q[0] : 8'h00;
      chk("state_code", int'(state_code), int'(m_code));
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(m_code == 4'b1000));
      chk("tx_valid", int'(tx_if.tx_valid), int'(exp_valid));
      chk("tx_data", int'(tx_if.tx_data), int'(exp_data));
      chk("cnt_send", int'(cnt_send), m_send);
      chk("overflow", int'(overflow), int'(m_ovf));
      if (stall_prev && !m_rst_last) begin
         chk("stall_data", int'(tx_if.tx_data), int'(data_prev));
         chk("stall_valid", int'(tx_if.tx_valid), 1);
      end
      stall_prev = tx_if.tx_valid && !tx_if.tx_ready;
      data_prev  = tx_if.tx_data;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
         rx_q.push_back(tx_if.tx_data);
         $display("xfer %0d: tx_data=0x%02h cnt_send=%0d", rx_q.size(), tx_if.tx_data, cnt_send);
      end
   end

   function automatic int rx_at(input int i);
      return (rx_q.size() > i) ? int'(rx_q[i]) : -1;
   endfunction

   task automatic sample(input logic [5:0] code, input logic sub);
      @(negedge clk_50M);
      dout_adc    = code;
      adc_ack_sub = sub;
      adc_ack     = 1'b1;
      repeat (4) @(negedge clk_50M);
      adc_ack = 1'b0;
      repeat (4) @(negedge clk_50M);
   endtask

   task automatic pulse_start();
      @(negedge clk_50M);
      start = 1'b1;
      @(negedge clk_50M);
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (!done && n < limit) begin
         @(negedge clk_50M);
         n++;
      end
      if (!done)
         chk("done_timeout", 0, 1);
      @(negedge clk_50M);
   endtask

   logic [5:0] basic_code [4] = '{6'h3F, 6'h00, 6'h15, 6'h2A};
   logic [5:0] bp_code    [5] = '{6'h01, 6'h22, 6'h13, 6'h3C, 6'h05};
   logic       bp_sub     [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      tx_if.tx_ready = 1'b0;
      repeat (3) @(negedge clk_50M);
      chk("rst_state_code", int'(state_code), 4'b0001);
      chk("rst_tx_valid", int'(tx_if.tx_valid), 0);
      rst = 1'b0;

      // strobes while idle must not be captured
      sample(6'h11, 1'b1);
      sample(6'h12, 1'b0);
      chk("idle_no_bytes", rx_q.size(), 0);
      chk("idle_state", int'(state_code), 4'b0001);

      // basic capture, with a stray start mid-acquisition
      tx_if.tx_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < NUM; i++) begin
         sample(basic_code[i % 4], 1'(i % 2));
         if (i == 1)
            pulse_start();
      end
      wait_done(200);
      chk("basic_b0", rx_at(0), 8'h3F);
      chk("basic_b1", rx_at(1), 8'h40);
      chk("basic_b2", rx_at(2), 8'h15);
      chk("basic_b3", rx_at(3), 8'h6A);
      chk("basic_count", int'(cnt_send), NUM);
      chk("basic_ovf", int'(overflow), 0);

      // strobe in DONE is ignored
      sample(6'h07, 1'b0);
      chk("done_no_extra", rx_q.size(), NUM);

      // backpressure: 5 captures while the UART is stalled
      rx_q.delete();
      tx_if.tx_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 5; i++)
         sample(bp_code[i], bp_sub[i]);
      tx_if.tx_ready = 1'b1;
      for (int i = 5; i < NUM; i++)
         sample(6'(8'h10 + i), 1'b0);
      wait_done(200);
      chk("bp_b0", rx_at(0), 8'h41);
      chk("bp_b1", rx_at(1), 8'h22);
      chk("bp_b2", rx_at(2), 8'h13);
      chk("bp_b3", rx_at(3), 8'h7C);
      chk("bp_b4", rx_at(4), 8'h45);

      // full FIFO, capture coincident with a transfer
      rx_q.delete();
      tx_if.tx_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < DEPTH; i++)
         sample(6'(i + 1), 1'b0);
      @(negedge clk_50M);
      dout_adc    = 6'h2B;
      adc_ack_sub = 1'b0;
      adc_ack     = 1'b1;
      repeat (2) @(negedge clk_50M);
      tx_if.tx_ready = 1'b1;
      @(negedge clk_50M);
      tx_if.tx_ready = 1'b0;
      @(negedge clk_50M);
      adc_ack = 1'b0;
      chk("fpp_ovf", int'(overflow), 0);
      repeat (4) @(negedge clk_50M);
      tx_if.tx_ready = 1'b1;
      for (int i = DEPTH + 1; i < NUM; i++)
         sample(6'(i + 1), 1'b1);
      wait_done(200);
      chk("fpp_b0", rx_at(0), 8'h01);
      chk("fpp_b16", rx_at(16), 8'h2B);
      chk("fpp_count", int'(cnt_send), NUM);
      chk("fpp_ovf_end", int'(overflow), 0);

      // overflow: 20 captures into a stalled 16-deep FIFO
      rx_q.delete();
      tx_if.tx_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < NUM; i++)
         sample(6'(i + 32), 1'(i % 2));
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_drain_state", int'(state_code), 4'b0100);
      tx_if.tx_ready = 1'b1;
      wait_done(200);
      chk("ovf_count", int'(cnt_send), DEPTH);
      chk("ovf_b0", rx_at(0), 8'h20);
      chk("ovf_b15", rx_at(15), 8'h6F);
      chk("ovf_rx_size", rx_q.size(), DEPTH);

      // reset mid-capture with one byte still buffered
      rx_q.delete();
      tx_if.tx_ready = 1'b1;
      pulse_start();
      sample(6'h31, 1'b0);
      sample(6'h32, 1'b0);
      tx_if.tx_ready = 1'b0;
      sample(6'h33, 1'b0);
      chk("pre_rst_count", int'(cnt_send), 2);
      @(negedge clk_50M);
      rst = 1'b1;
      @(negedge clk_50M);
      chk("mid_rst_state", int'(state_code), 4'b0001);
      chk("mid_rst_valid", int'(tx_if.tx_valid), 0);
      chk("mid_rst_count", int'(cnt_send), 0);
      rst = 1'b0;
      rx_q.delete();
      tx_if.tx_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < NUM; i++)
         sample(6'((i * 5 + 7) % 64), 1'((i / 2) % 2));
      wait_done(200);
      chk("rearm_b0", rx_at(0), 8'h07);
      chk("rearm_count", int'(cnt_send), NUM);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/adc_capture_stream.md
# adc_capture_stream

Capture-and-stream stage between the Giraffe sub-ADC output bus and the UART transmitter. It synchronises the ADC's asynchronous `adc_ack` strobe and latches each `dout_adc` code. Each code is packed into one byte, buffered in a small FIFO and handed to the UART TX with a valid/ready handshake. The block stops after a programmed number of samples, and exposes progress counters and a state code for the board LEDs.

## Interface
- `N_bit`, 6: sub-ADC code width; must be ≤ 6.
- `NUM_Sampled`, 102400: samples per acquisition.
- `FIFO_DEPTH`, 16: byte FIFO depth; power of two.
- `CNT_W`, 18: width of the sample and send counters.

Ports:
- `clk_50M`  in  1  system clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that arms an acquisition; ignored unless IDLE or DONE.
- `adc_ack`  in  1  asynchronous per-conversion strobe; rising edge marks a valid `dout_adc`.
- `adc_ack_sub`  in  1  asynchronous sub-conversion flag, sampled with the code.
- `dout_adc`  in  N_bit  sub-ADC code; stable ≥ 4 clk periods after `adc_ack` rises.
- `tx_data`  out  8  byte to UART.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  UART accepts; a transfer occurs when valid & ready.
- `busy`  out  1  high in CAPTURE or DRAIN.
- `done`  out  1  high in DONE.
- `overflow`  out  1  sticky; a sample was dropped because the FIFO was full.
- `cnt_send`  out  CNT_W  bytes transferred this acquisition.
- `state_code`  out  4  one-hot state for LEDs.

## Operation
- Reset values: all outputs 0 except `state_code` = 4'b0001 (IDLE); FIFO empty; synchronisers cleared.
- `adc_ack` and `adc_ack_sub` pass through 2-FF synchronisers. A rising-edge detect on synchronised ack gives a one-cycle `cap` pulse.
- Byte format: {1'b0, sub_sync, zero-extended dout_adc[5:0]}. `dout_adc` is registered directly in the `cap` cycle.
- States:
  - IDLE: waits for `start`, then goes to CAPTURE and clears `cnt_cap`, `cnt_send` and `overflow`.
  - CAPTURE: each `cap` increments `cnt_cap`.
    - FIFO not full: the byte is written.
    - FIFO full: the byte is dropped and `overflow` is set.
    - When `cnt_cap` reaches NUM_Sampled, goes to DRAIN.
  - DRAIN: ignores `cap` and pops until the FIFO is empty, then goes to DONE.
  - DONE: holds `done`; `start` re-arms, as from IDLE.
- `state_code`: IDLE 0001, CAPTURE 0010, DRAIN 0100, DONE 1000.
- `cap` outside CAPTURE is ignored, with no FIFO write and no count.
- Full FIFO with a pop in the same cycle as `cap`: the write is accepted and no overflow is recorded.
- Empty FIFO with a write in the same cycle: no pop that cycle, because `tx_valid` was low.
- `cnt_send` increments on every transfer. At DONE, `cnt_send` + dropped samples = NUM_Sampled.
- `start` while `busy` is ignored.
- `rst` asserted mid-acquisition returns the block to the reset values next edge; FIFO contents are discarded.

## Timing
- `adc_ack` rise to `cap`: 2–3 clk (synchroniser plus edge detect). The FIFO write happens on the `cap` edge.
- FIFO is first-word-fall-through. `tx_valid` rises 1 clk after the write into an empty FIFO, and is high whenever the FIFO is non-empty in CAPTURE or DRAIN.
- `tx_data`/`tx_valid` are held stable while `tx_valid` & !`tx_ready`. The next byte is presented the cycle after a transfer.
- CAPTURE→DRAIN happens on the edge after the `cap` that makes `cnt_cap` = NUM_Sampled.
- DRAIN→DONE happens on the edge after the transfer that empties the FIFO.
- `done`/`busy` are registered and follow the state register directly.
- Minimum `adc_ack` high and low time: 3 clk each; shorter pulses may be missed.

## Structure
- Package `giraffe_pkg`:
  - state enum and its one-hot LED encoding;
  - byte-format field positions;
  - default `CNT_W`.
- Sub-module `adc_byte_fifo`: synchronous FWFT FIFO, 8-bit, depth `FIFO_DEPTH`, with full/empty. Pointers are log2(depth)+1 bits wide, so full/empty is decided by the MSB wrap.
- The top-level module holds the synchronisers, edge detect, FSM and counters.

## Test plan
- Basic capture: NUM_Sampled=4, `tx_ready`=1, codes 0x3F,0x00,0x15,0x2A with sub=0,1,0,1 → bytes 0x3F,0x40,0x15,0x6A; DONE with `cnt_send`=4 and `overflow`=0.
- Backpressure: `tx_ready`=0 for 20 cycles, 5 captures → 5 bytes in order once ready rises; `tx_data` stable while stalled.
- Overflow: FIFO_DEPTH=16, `tx_ready`=0, 20 captures with NUM_Sampled=20 → `overflow`=1, FIFO holds the first 16 bytes; after release `cnt_send`=16 and DONE.
- Full-plus-pop: FIFO full, `cap` coincident with a transfer → write accepted, `overflow` stays 0.
- Reset mid-capture: `rst` after 3 of 8 samples → next cycle `state_code`=0001, `tx_valid`=0, `cnt_send`=0; a new `start` captures 8 fresh bytes.
- Spurious inputs: `adc_ack` edges in IDLE and `start` during CAPTURE → no FIFO writes, no count change, no restart.
